hough_line_accum: RTL and testbench

Parametrised Hough line detector for the edge-map pipeline: accepts a raster-order stream of W×H edge-magnitude pixels, votes every edge pixel into an N_THETA × RHO_BINS accumulator, then scans the accumulator and reports the strongest line as (rho, theta, votes). It sits between the edge-detection stage and the UART result formatter. It is the full-accumulator successor to the single-angle centroid estimator.

---
 rtl/hough_line_accum.sv | 272 +++++++++++++++++++++++++++
 tb/tb_hough_line_accum.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/hough_line_accum.sv
`default_nettype none
// ============================================================================
// Module   : hough_line_accum
// Function : Votes edge pixels into an N_THETA x RHO_BINS accumulator, then
//            scans it and reports the strongest line as (rho, theta, votes).
// Revision : 1.0 - initial release
// ============================================================================
module hough_line_accum #(
  parameter int W         = 16,
  parameter int H         = 16,
  parameter int PIX_W     = 8,
  parameter int THRESH    = 0,
  parameter int N_THETA   = 8,
  parameter int RHO_BINS  = 2 * (W + H),
  parameter int VOTE_W    = 8,
  parameter int MIN_VOTES = 4
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                start,
  input  logic [PIX_W-1:0]                    s_data,
  input  logic                                s_valid,
  output logic                                s_ready,
  output logic                                busy,
  output logic                                done,
  output logic                                line_found,
  output logic signed [$clog2(RHO_BINS)-1:0]  rho,
  output logic [$clog2(N_THETA)-1:0]          theta,
  output logic [7:0]                          theta_deg,
  output logic [VOTE_W-1:0]                   votes
);

  localparam int c_CELLS   = N_THETA * RHO_BINS;
  localparam int c_AW      = $clog2(c_CELLS);
  localparam int c_RW      = $clog2(RHO_BINS);
  localparam int c_TW      = $clog2(N_THETA);
  localparam int c_XW      = (W > 1) ? $clog2(W) : 1;
  localparam int c_YW      = (H > 1) ? $clog2(H) : 1;
  localparam int c_RHO_OFF = RHO_BINS / 2;
  localparam logic [VOTE_W-1:0] c_VMAX = '1;

  // Q1.8 cos/sin evaluated at elaboration via a Taylor series, rounded half away from zero
  function automatic int trig_q8(input int t, input bit want_sin);
    real pi, ang, x, term, sum, v;
    pi   = 3.14159265358979323846;
    ang  = pi * t / N_THETA;
    x    = want_sin ? (pi / 2.0 - ang) : ang;
    term = 1.0;
    sum  = 1.0;
    for (int n = 1; n < 24; n++) begin
      term = -term * x * x / ((2.0 * n - 1.0) * (2.0 * n));
      sum  = sum + term;
    end
    v = sum * 256.0;
    return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
  endfunction

  function automatic logic [c_AW-1:0] cell_addr(input logic [c_TW-1:0] t,
                                                input logic [c_RW-1:0] b);
    return c_AW'(int'(t) * RHO_BINS + int'(b));
  endfunction

  logic signed [9:0] w_cos [N_THETA];
  logic signed [9:0] w_sin [N_THETA];

  for (genvar k = 0; k < N_THETA; k++) begin : g_trig
    localparam int c_C = trig_q8(k, 1'b0);
    localparam int c_S = trig_q8(k, 1'b1);
    assign w_cos[k] = 10'(c_C);
    assign w_sin[k] = 10'(c_S);
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_ACCUM  = 3'd2,
    S_SEARCH = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t r_state, w_state_nxt;

  logic [VOTE_W-1:0] r_acc [c_CELLS];

  logic [c_XW-1:0]   r_x, r_vote_x;
  logic [c_YW-1:0]   r_y, r_vote_y;
  logic [c_TW-1:0]   r_vote_k, r_scan_t, r_best_t;
  logic [c_RW-1:0]   r_scan_bin, r_best_bin;
  logic [VOTE_W-1:0] r_best_v;
  logic              r_voting, r_vote_last;

  logic              w_accept, w_edge, w_last_pix, w_vote_end, w_scan_end;
  logic signed [31:0] w_sum, w_bin_raw;
  logic [c_RW-1:0]   w_vote_bin;
  logic [c_AW-1:0]   w_addr;
  logic [VOTE_W-1:0] w_cell, w_wr_data;
  logic              w_we;
  logic              w_take;
  logic [VOTE_W-1:0] w_nb_v;
  logic [c_TW-1:0]   w_nb_t;
  logic [c_RW-1:0]   w_nb_bin;

  assign w_accept   = s_valid && s_ready;
  assign w_edge     = s_data > PIX_W'(THRESH);
  assign w_last_pix = (r_x == c_XW'(W - 1)) && (r_y == c_YW'(H - 1));
  assign w_vote_end = r_voting && (r_vote_k == c_TW'(N_THETA - 1));
  assign w_scan_end = (r_scan_t == c_TW'(N_THETA - 1)) && (r_scan_bin == c_RW'(RHO_BINS - 1));

  // rho bin of the vote in flight; arithmetic shift gives floor for negative sums
  always_comb begin
    w_sum = $signed(32'(r_vote_x)) * 32'(w_cos[r_vote_k])
          + $signed(32'(r_vote_y)) * 32'(w_sin[r_vote_k]);
    w_bin_raw = (w_sum >>> 8) + 32'(c_RHO_OFF);
    if (w_bin_raw < 0)
      w_vote_bin = '0;
    else if (w_bin_raw > 32'(RHO_BINS - 1))
      w_vote_bin = c_RW'(RHO_BINS - 1);
    else
      w_vote_bin = c_RW'(w_bin_raw);
  end

  // Single read-modify-write port: scan address in CLEAR/SEARCH, vote address in ACCUM
  always_comb begin
    w_we      = 1'b0;
    w_wr_data = '0;
    w_addr    = cell_addr(r_scan_t, r_scan_bin);
    if (r_state == S_ACCUM)
      w_addr = cell_addr(r_vote_k, w_vote_bin);
    w_cell = r_acc[w_addr];
    if (r_state == S_CLEAR) begin
      w_we = 1'b1;
    end else if (r_state == S_ACCUM && r_voting) begin
      w_we      = 1'b1;
      w_wr_data = (w_cell == c_VMAX) ? w_cell : w_cell + VOTE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_we)
      r_acc[w_addr] <= w_wr_data;
  end

  // Cell (0,0) seeds the best; later cells replace it only when strictly larger
  always_comb begin
    w_take   = ((r_scan_t == '0) && (r_scan_bin == '0)) || (w_cell > r_best_v);
    w_nb_v   = w_take ? w_cell     : r_best_v;
    w_nb_t   = w_take ? r_scan_t   : r_best_t;
    w_nb_bin = w_take ? r_scan_bin : r_best_bin;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = (r_state != S_IDLE);
    done        = 1'b0;
    unique case (r_state)
      S_IDLE:   if (start) w_state_nxt = S_CLEAR;
      S_CLEAR:  if (w_scan_end) w_state_nxt = S_ACCUM;
      S_ACCUM: begin
        if ((w_accept && !w_edge && w_last_pix) || (w_vote_end && r_vote_last))
          w_state_nxt = S_SEARCH;
      end
      S_SEARCH: if (w_scan_end) w_state_nxt = S_DONE;
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_x         <= '0;
      r_y         <= '0;
      r_vote_x    <= '0;
      r_vote_y    <= '0;
      r_vote_k    <= '0;
      r_voting    <= 1'b0;
      r_vote_last <= 1'b0;
      r_scan_t    <= '0;
      r_scan_bin  <= '0;
      r_best_v    <= '0;
      r_best_t    <= '0;
      r_best_bin  <= '0;
      s_ready     <= 1'b0;
      line_found  <= 1'b0;
      rho         <= '0;
      theta       <= '0;
      theta_deg   <= '0;
      votes       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_x        <= '0;
          r_y        <= '0;
          r_voting   <= 1'b0;
          r_scan_t   <= '0;
          r_scan_bin <= '0;
          s_ready    <= 1'b0;
        end
        S_CLEAR, S_SEARCH: begin
          if (w_scan_end) begin
            r_scan_t   <= '0;
            r_scan_bin <= '0;
          end else if (r_scan_bin == c_RW'(RHO_BINS - 1)) begin
            r_scan_bin <= '0;
            r_scan_t   <= r_scan_t + c_TW'(1);
          end else begin
            r_scan_bin <= r_scan_bin + c_RW'(1);
          end
          if (r_state == S_CLEAR) begin
            s_ready <= w_scan_end;
          end else begin
            r_best_v   <= w_nb_v;
            r_best_t   <= w_nb_t;
            r_best_bin <= w_nb_bin;
            if (w_scan_end) begin
              votes <= w_nb_v;
              if (int'(w_nb_v) >= MIN_VOTES) begin
                line_found <= 1'b1;
                rho        <= c_RW'(int'(w_nb_bin) - c_RHO_OFF);
                theta      <= w_nb_t;
                theta_deg  <= 8'((int'(w_nb_t) * 180) / N_THETA);
              end else begin
                line_found <= 1'b0;
                rho        <= '0;
                theta      <= '0;
                theta_deg  <= '0;
              end
            end
          end
        end
        S_ACCUM: begin
          if (r_voting) begin
            r_vote_k <= r_vote_k + c_TW'(1);
            if (w_vote_end) begin
              r_voting <= 1'b0;
              s_ready  <= !r_vote_last;
            end
          end else if (w_accept) begin
            if (r_x == c_XW'(W - 1)) begin
              r_x <= '0;
              r_y <= r_y + c_YW'(1);
            end else begin
              r_x <= r_x + c_XW'(1);
            end
            if (w_edge) begin
              r_voting    <= 1'b1;
              r_vote_k    <= '0;
              r_vote_x    <= r_x;
              r_vote_y    <= r_y;
              r_vote_last <= w_last_pix;
              s_ready     <= 1'b0;
            end else if (w_last_pix) begin
              s_ready <= 1'b0;
            end
          end
        end
        default: s_ready <= 1'b0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hough_line_accum.sv
`default_nettype none
// Testbench for hough_line_accum: random and directed frames against a
// plain-arithmetic accumulator model, on default and 4-bit vote instances.
module tb_hough_line_accum;

  localparam int W    = 16;
  localparam int H    = 16;
  localparam int NT   = 8;
  localparam int RB   = 64;
  localparam int CL   = NT * RB;
  localparam int NPIX = W * H;
  localparam int MINV = 4;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic              s_valid = 1'b0;
  logic [7:0]        s_data = '0;

  logic              s_ready, busy, done, line_found;
  logic signed [5:0] rho;
  logic [2:0]        theta;
  logic [7:0]        theta_deg, votes;

  logic              s_ready4, busy4, done4, line_found4;
  logic signed [5:0] rho4;
  logic [2:0]        theta4;
  logic [7:0]        theta_deg4;
  logic [3:0]        votes4;

  int checks = 0;
  int errors = 0;
  int img [NPIX];
  int cos_q8 [NT] = '{256, 237, 181, 98, 0, -98, -181, -237};
  int sin_q8 [NT] = '{0, 98, 181, 237, 256, 237, 181, 98};

  always #5 clk = ~clk;

  hough_line_accum dut (
    .clk(clk), .reset_n(reset_n), .start(start), .s_data(s_data),
    .s_valid(s_valid), .s_ready(s_ready), .busy(busy), .done(done),
    .line_found(line_found), .rho(rho), .theta(theta),
    .theta_deg(theta_deg), .votes(votes)
  );

  hough_line_accum #(.VOTE_W(4)) dut_sat (
    .clk(clk), .reset_n(reset_n), .start(start), .s_data(s_data),
    .s_valid(s_valid), .s_ready(s_ready4), .busy(busy4), .done(done4),
    .line_found(line_found4), .rho(rho4), .theta(theta4),
    .theta_deg(theta_deg4), .votes(votes4)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int floor256(input int v);
    return (v >= 0) ? v / 256 : -((-v + 255) / 256);
  endfunction

  // Votes every edge pixel of img, then finds the first strictly-largest cell.
  function automatic void model(input int vmax, output int pv, output int pt, output int pb);
    int acc [NT][RB];
    int b;
    for (int t = 0; t < NT; t++)
      for (int r = 0; r < RB; r++)
        acc[t][r] = 0;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        if (img[y * W + x] > 0)
          for (int t = 0; t < NT; t++) begin
            b = floor256(x * cos_q8[t] + y * sin_q8[t]) + RB / 2;
            if (b < 0) b = 0;
            if (b > RB - 1) b = RB - 1;
            if (acc[t][b] < vmax) acc[t][b]++;
          end
    pv = acc[0][0]; pt = 0; pb = 0;
    for (int t = 0; t < NT; t++)
      for (int r = 0; r < RB; r++)
        if (acc[t][r] > pv) begin
          pv = acc[t][r]; pt = t; pb = r;
        end
  endfunction

  task automatic check_result(input string tag, input int vmax, input int g_lf,
                              input int g_rho, input int g_t, input int g_deg, input int g_v);
    int pv, pt, pb;
    bit f;
    model(vmax, pv, pt, pb);
    f = (pv >= MINV);
    check({tag, ".found"}, g_lf, int'(f));
    check({tag, ".rho"},   g_rho, f ? pb - RB / 2 : 0);
    check({tag, ".theta"}, g_t,   f ? pt : 0);
    check({tag, ".deg"},   g_deg, f ? (pt * 180) / NT : 0);
    check({tag, ".votes"}, g_v,   pv);
  endtask

  task automatic run_frame(input string tag, input bit rand_valid, input bit start_in_search);
    int idx, ne, exp_done, done_cyc, ndone, ndone4, first_edge_acc;
    bit gap_checked;
    ne = 0;
    for (int i = 0; i < NPIX; i++) if (img[i] > 0) ne++;
    exp_done = 1 + CL + NPIX + ne * NT + CL;
    idx = 0; ndone = 0; ndone4 = 0; done_cyc = -1; first_edge_acc = -1; gap_checked = 1'b0;
    @(negedge clk);
    check({tag, ".idle"}, int'(busy), 0);
    start = 1'b1;
    s_valid = 1'b0;
    for (int c = 1; c < 8000; c++) begin
      @(negedge clk);
      start = (start_in_search && c == exp_done - 20) ? 1'b1 : 1'b0;
      if (done) begin
        ndone++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (done4) ndone4++;
      if (first_edge_acc >= 0 && !gap_checked && s_ready) begin
        check({tag, ".ready_gap"}, c - first_edge_acc - 1, NT);
        gap_checked = 1'b1;
      end
      if (idx < NPIX) begin
        s_valid = rand_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
        s_data  = 8'(img[idx]);
        if (s_valid && s_ready) begin
          if (img[idx] > 0 && first_edge_acc < 0 && idx < NPIX - 1) first_edge_acc = c;
          idx++;
        end
      end else begin
        s_valid = 1'($urandom_range(0, 1));
        s_data  = 8'($urandom_range(0, 255));
      end
      if (done_cyc >= 0 && c >= done_cyc + 4) break;
    end
    s_valid = 1'b0;
    start   = 1'b0;
    check({tag, ".done_seen"}, int'(done_cyc >= 0), 1);
    if (!rand_valid) check({tag, ".done_cycle"}, done_cyc, exp_done);
    check({tag, ".done_pulses"}, ndone, 1);
    check({tag, ".sat_done_pulses"}, ndone4, 1);
    check({tag, ".busy_after"}, int'(busy), 0);
    check_result(tag, 255, int'(line_found), int'(rho), int'(theta), int'(theta_deg), int'(votes));
    check_result({tag, "_sat"}, 15, int'(line_found4), int'(rho4), int'(theta4),
                 int'(theta_deg4), int'(votes4));
  endtask

  task automatic fill(input int kind, input int arg);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        case (kind)
          1:       img[y * W + x] = (x == arg) ? 200 : 0;
          2:       img[y * W + x] = (y == arg) ? 255 : 0;
          3:       img[y * W + x] = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 255) : 0;
          default: img[y * W + x] = 0;
        endcase
      end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst.s_ready", int'(s_ready), 0);
    check("rst.busy", int'(busy), 0);
    check("rst.done", int'(done), 0);
    check("rst.found", int'(line_found), 0);
    check("rst.rho", int'(rho), 0);
    check("rst.theta", int'(theta), 0);
    check("rst.deg", int'(theta_deg), 0);
    check("rst.votes", int'(votes), 0);
    reset_n = 1'b1;

    fill(1, 5);  run_frame("vert", 1'b0, 1'b0);
    check("vert.const_rho", int'(rho), 5);
    check("vert.const_votes", int'(votes), 16);
    check("vert.sat_votes", int'(votes4), 15);
    fill(2, 9);  run_frame("horiz", 1'b0, 1'b0);
    check("horiz.const_deg", int'(theta_deg), 90);
    fill(0, 0);  run_frame("empty", 1'b0, 1'b0);
    fill(0, 0);  img[0] = 1;
    run_frame("bp", 1'b0, 1'b0);
    run_frame("bp_rv", 1'b1, 1'b0);

    for (int i = 0; i < 4; i++) begin
      fill(3, 0);
      if (i % 2 == 1)
        for (int x = 0; x < W; x++) img[(x % H) * W + x] = 100;
      run_frame($sformatf("rand%0d", i), 1'(i % 2), 1'b0);
    end

    // abandon a frame part-way through ACCUM
    fill(1, 5);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    s_valid = 1'b1;
    s_data = 8'd200;
    repeat (CL + 100) @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst.busy", int'(busy), 0);
    check("midrst.s_ready", int'(s_ready), 0);
    check("midrst.found", int'(line_found), 0);
    s_valid = 1'b0;
    reset_n = 1'b1;
    run_frame("vert_after_rst", 1'b0, 1'b0);

    fill(1, 5);  run_frame("start_in_search", 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
